// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Groups the signals exchanged between the 5-stage pipeline datapath and the
// central hazard controller.
//   master : pipeline side. It drives the stage register indices, the hazard
//            qualifiers and mdu_done, and receives the controls.
//   slave  : hazard controller side (pipe_hazard_ctrl).
// Signal names keep the stage suffix (D/E/M/W) of the datapath they belong to.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
    // ID-stage sources
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic        rs1_useD;
    logic        rs2_useD;
    // EX-stage instruction
    logic [4:0]  rs1E;
    logic [4:0]  rs2E;
    logic [4:0]  rdE;
    logic        mem_readE;
    logic        mduE;
    logic        redirectE;
    // MEM / WB writers
    logic [4:0]  rdM;
    logic        reg_writeM;
    logic [4:0]  rdW;
    logic        reg_writeW;
    // MDU handshake
    logic        mdu_done;
    logic        mdu_start;
    logic        mdu_busy;
    // Pipeline register controls
    logic        enF;
    logic        enD;
    logic        clcD;
    logic        enE;
    logic        clcE;
    logic        enM;
    logic        clcM;
    // Forwarding selects
    logic [1:0]  fwdAE;
    logic [1:0]  fwdBE;
    // Debug counters
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output rs1D, rs2D, rs1_useD, rs2_useD,
        output rs1E, rs2E, rdE, mem_readE, mduE, redirectE,
        output rdM, reg_writeM, rdW, reg_writeW, mdu_done,
        input  enF, enD, clcD, enE, clcE, enM, clcM,
        input  fwdAE, fwdBE, mdu_start, mdu_busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1D, rs2D, rs1_useD, rs2_useD,
        input  rs1E, rs2E, rdE, mem_readE, mduE, redirectE,
        input  rdM, reg_writeM, rdW, reg_writeW, mdu_done,
        output enF, enD, clcD, enE, clcE, enM, clcM,
        output fwdAE, fwdBE, mdu_start, mdu_busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central hazard controller for the 5-stage RV32 pipeline.
//   - Drives en/clc of the IF/ID, ID/EX and EX/MEM registers and the PC enable.
//     Priority from highest to lowest: MDU stall, EX redirect, load-use.
//   - Generates EX operand forwarding selects (00 regfile, 01 WB, 10 MEM).
//   - Sequences the multi-cycle MDU (IDLE/BUSY) with a one-cycle start pulse.
//   - Counts stall cycles (enF=0) and accepted redirects.
// Ports:
//   clk  : pipeline clock, posedge
//   rstn : synchronous active-low reset
//   hz   : pipe_hazard_ctrl_if.slave bundle (stage indices in, controls out)
// Controls and fwd selects are combinational from the inputs and the FSM state.
// The counters and the FSM state are registered.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl (
    input  logic               clk,
    input  logic               rstn,
    pipe_hazard_ctrl_if.slave  hz
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_mdu_start;
    logic        w_mdu_stall;
    logic        w_load_use;
    logic        w_flush;
    logic        w_enF;
    logic        w_enD;
    logic        w_clcD;
    logic        w_enE;
    logic        w_clcE;
    logic        w_enM;
    logic        w_clcM;
    logic [1:0]  w_fwdA;
    logic [1:0]  w_fwdB;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // MEM beats WB so the youngest producer is used. x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // MDU FSM next-state, start pulse and stall request
    always_comb begin
        w_state_nxt = r_state;
        w_mdu_start = 1'b0;
        w_mdu_stall = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // mdu_done is meaningless here and is deliberately ignored
                if (hz.mduE) begin
                    w_state_nxt = ST_BUSY;
                    w_mdu_start = 1'b1;
                    w_mdu_stall = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // The done cycle itself is not stalled, so the op leaves EX
                // at the edge that ends it
                if (hz.mdu_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BUSY;
                    w_mdu_stall = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Load-use detection: the load result is not ready until after MEM
    always_comb begin
        w_load_use = 1'b0;
        if (hz.mem_readE && (hz.rdE != 5'd0)) begin
            w_load_use = (hz.rs1_useD && (hz.rdE == hz.rs1D)) ||
                         (hz.rs2_useD && (hz.rdE == hz.rs2D));
        end else begin
            w_load_use = 1'b0;
        end
    end

    // Prioritised pipeline register controls. clc is only raised with en
    always_comb begin
        w_enF   = 1'b1;
        w_enD   = 1'b1;
        w_clcD  = 1'b0;
        w_enE   = 1'b1;
        w_clcE  = 1'b0;
        w_enM   = 1'b1;
        w_clcM  = 1'b0;
        w_flush = 1'b0;
        if (!rstn) begin
            // Flush every stage while reset is held
            w_clcD = 1'b1;
            w_clcE = 1'b1;
            w_clcM = 1'b1;
        end else if (w_mdu_stall) begin
            // Freeze IF..EX and bubble MEM. Redirect/load-use wait for EX
            w_enF  = 1'b0;
            w_enD  = 1'b0;
            w_enE  = 1'b0;
            w_clcM = 1'b1;
        end else if (hz.redirectE) begin
            // Squash the wrong-path instructions in IF and ID
            w_clcD  = 1'b1;
            w_clcE  = 1'b1;
            w_flush = 1'b1;
        end else if (w_load_use) begin
            w_enF  = 1'b0;
            w_enD  = 1'b0;
            w_clcE = 1'b1;
        end else begin
            w_enF = 1'b1;
        end
    end

    // Forwarding selects, forced to the register file during reset
    always_comb begin
        w_fwdA = 2'b00;
        w_fwdB = 2'b00;
        if (rstn) begin
            w_fwdA = fwd_sel(hz.rs1E, hz.rdM, hz.reg_writeM, hz.rdW, hz.reg_writeW);
            w_fwdB = fwd_sel(hz.rs2E, hz.rdM, hz.reg_writeM, hz.rdW, hz.reg_writeW);
        end else begin
            w_fwdA = 2'b00;
            w_fwdB = 2'b00;
        end
    end

    // FSM state and debug counters. The counters wrap naturally at 2^32
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_enF) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign hz.enF      = w_enF;
    assign hz.enD      = w_enD;
    assign hz.clcD     = w_clcD;
    assign hz.enE      = w_enE;
    assign hz.clcE     = w_clcE;
    assign hz.enM      = w_enM;
    assign hz.clcM     = w_clcM;
    assign hz.fwdAE    = w_fwdA;
    assign hz.fwdBE    = w_fwdB;
    assign hz.mdu_start = w_mdu_start & rstn;
    assign hz.mdu_busy  = (r_state == ST_BUSY);
    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl. Each cycle, inputs are driven
// just after the falling edge and the expected control word is queued.
// The word is then popped and compared 1 time unit later. Counters are
// compared against values the bench tracks itself.
// Control word layout: {enF,enD,clcD,enE,clcE,enM,clcM, start, busy, fwdA, fwdB}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] C_NORM  = 7'b1101010;
    localparam logic [6:0] C_LU    = 7'b0001110;
    localparam logic [6:0] C_REDIR = 7'b1111110;
    localparam logic [6:0] C_MDU   = 7'b0000011;
    localparam logic [6:0] C_RST   = 7'b1111111;

    typedef struct {
        string       tag;
        logic [12:0] v;
    } exp_t;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    pipe_hazard_ctrl_if hif();

    pipe_hazard_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .hz   (hif.slave)
    );

    wire [12:0] obs = {hif.enF, hif.enD, hif.clcD, hif.enE, hif.clcE, hif.enM, hif.clcM,
                       hif.mdu_start, hif.mdu_busy, hif.fwdAE, hif.fwdBE};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] ev(logic [6:0] c, logic st, logic bz,
                                       logic [1:0] fa, logic [1:0] fb);
        return {c, st, bz, fa, fb};
    endfunction

    task automatic sb_push(input string tag, input logic [12:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb_q.push_back(e);
    endtask

    task automatic idle_inputs();
        hif.rs1D = 5'd0; hif.rs2D = 5'd0; hif.rs1_useD = 1'b0; hif.rs2_useD = 1'b0;
        hif.rs1E = 5'd0; hif.rs2E = 5'd0; hif.rdE = 5'd0;
        hif.mem_readE = 1'b0; hif.mduE = 1'b0; hif.redirectE = 1'b0;
        hif.rdM = 5'd0; hif.reg_writeM = 1'b0; hif.rdW = 5'd0; hif.reg_writeW = 1'b0;
        hif.mdu_done = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        idle_inputs();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sb_push("reset_ctrl", ev(C_RST, 1'b0, 1'b0, 2'b00, 2'b00));
        #1;
        e = sb_q.pop_front(); n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.v); end
        n_tests++;
        if (hif.stall_cnt !== 32'd0 || hif.flush_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %h/%h expected 0/0", hif.stall_cnt, hif.flush_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
        sb_push("post_reset_ctrl", ev(C_NORM, 1'b0, 1'b0, 2'b00, 2'b00));
        #1;
        e = sb_q.pop_front(); n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.v); end
        @(negedge clk);
    endtask

    // Columns: mem_readE rdE rs1D rs1_useD rs2D rs2_useD | ctrl | stall_cnt seen
    task automatic test_load_use();
        logic [4:0] t_rdE  [6] = '{5'd5, 5'd5, 5'd0, 5'd5, 5'd9, 5'd0};
        logic [4:0] t_rs1  [6] = '{5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 5'd0};
        logic [4:0] t_rs2  [6] = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd9, 5'd0};
        logic       t_mr   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       t_u1   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       t_u2   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [6:0] t_c    [6] = '{C_LU, C_NORM, C_NORM, C_NORM, C_LU, C_NORM};
        logic [31:0] t_cnt [6] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            hif.mem_readE = t_mr[i]; hif.rdE = t_rdE[i];
            hif.rs1D = t_rs1[i]; hif.rs1_useD = t_u1[i];
            hif.rs2D = t_rs2[i]; hif.rs2_useD = t_u2[i];
            sb_push($sformatf("load_use_%0d", i), ev(t_c[i], 1'b0, 1'b0, 2'b00, 2'b00));
            #1;
            e = sb_q.pop_front(); n_tests++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.v); end
            n_tests++;
            if (hif.stall_cnt !== t_cnt[i]) begin
                n_fail++; $display("FAIL load_use_cnt_%0d: got %0d expected %0d", i, hif.stall_cnt, t_cnt[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        exp_t e;
        idle_inputs();
        hif.mem_readE = 1'b1; hif.rdE = 5'd5; hif.rs1D = 5'd5; hif.rs1_useD = 1'b1;
        hif.redirectE = 1'b1;
        sb_push("redirect_over_lu", ev(C_REDIR, 1'b0, 1'b0, 2'b00, 2'b00));
        #1;
        e = sb_q.pop_front(); n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.v); end
        @(negedge clk);
        idle_inputs();
        sb_push("redirect_after", ev(C_NORM, 1'b0, 1'b0, 2'b00, 2'b00));
        #1;
        e = sb_q.pop_front(); n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.v); end
        n_tests++;
        if (hif.flush_cnt !== 32'd1 || hif.stall_cnt !== 32'd2) begin
            n_fail++; $display("FAIL redirect_cnt: got flush %0d stall %0d expected 1 2", hif.flush_cnt, hif.stall_cnt);
        end
        @(negedge clk);
    endtask

    // Two back-to-back ops, done returned 4 cycles after start, redirect mid-BUSY
    task automatic test_mdu();
        exp_t e;
        for (int op = 0; op < 2; op++) begin
            for (int k = 0; k < 5; k++) begin
                idle_inputs();
                hif.mduE      = 1'b1;
                hif.mdu_done  = (k == 4);
                hif.redirectE = (k == 2);
                if (k == 0)
                    sb_push($sformatf("mdu%0d_c%0d", op, k), ev(C_MDU, 1'b1, 1'b0, 2'b00, 2'b00));
                else if (k < 4)
                    sb_push($sformatf("mdu%0d_c%0d", op, k), ev(C_MDU, 1'b0, 1'b1, 2'b00, 2'b00));
                else
                    sb_push($sformatf("mdu%0d_c%0d", op, k), ev(C_NORM, 1'b0, 1'b1, 2'b00, 2'b00));
                #1;
                e = sb_q.pop_front(); n_tests++;
                if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.v); end
                @(negedge clk);
            end
            n_tests++;
            if (hif.stall_cnt !== 32'd2 + 32'd4 * (op + 1) || hif.flush_cnt !== 32'd1) begin
                n_fail++; $display("FAIL mdu%0d_cnt: got stall %0d flush %0d expected %0d 1",
                                   op, hif.stall_cnt, hif.flush_cnt, 2 + 4 * (op + 1));
            end
        end
        idle_inputs();
        sb_push("mdu_done_idle", ev(C_NORM, 1'b0, 1'b0, 2'b00, 2'b00));
        #1;
        e = sb_q.pop_front(); n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.v); end
        @(negedge clk);
    endtask

    // Columns: rs1E rs2E rdM wM rdW wW | fwdA fwdB
    task automatic test_fwd();
        logic [4:0] t_r1 [6] = '{5'd7, 5'd7, 5'd0, 5'd3, 5'd3, 5'd7};
        logic [4:0] t_r2 [6] = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd7, 5'd3};
        logic [4:0] t_dm [6] = '{5'd7, 5'd7, 5'd0, 5'd7, 5'd7, 5'd3};
        logic       t_wm [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [4:0] t_dw [6] = '{5'd7, 5'd7, 5'd0, 5'd7, 5'd7, 5'd7};
        logic       t_ww [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] t_fa [6] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
        logic [1:0] t_fb [6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            hif.rs1E = t_r1[i]; hif.rs2E = t_r2[i];
            hif.rdM = t_dm[i]; hif.reg_writeM = t_wm[i];
            hif.rdW = t_dw[i]; hif.reg_writeW = t_ww[i];
            sb_push($sformatf("fwd_%0d", i), ev(C_NORM, 1'b0, 1'b0, t_fa[i], t_fb[i]));
            #1;
            e = sb_q.pop_front(); n_tests++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.v); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_busy();
        exp_t e;
        idle_inputs();
        hif.mduE = 1'b1;
        @(negedge clk);                       // cycle 0 start, cycle 1 BUSY
        @(negedge clk);                       // BUSY cycle 2
        rstn = 1'b0;
        hif.rs1E = 5'd7; hif.rdM = 5'd7; hif.reg_writeM = 1'b1;
        sb_push("rst_busy_during", ev(C_RST, 1'b0, 1'b1, 2'b00, 2'b00));
        #1;
        e = sb_q.pop_front(); n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.v); end
        @(negedge clk);
        rstn = 1'b1;
        idle_inputs();
        hif.mdu_done = 1'b1;
        sb_push("rst_busy_after", ev(C_NORM, 1'b0, 1'b0, 2'b00, 2'b00));
        #1;
        e = sb_q.pop_front(); n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.v); end
        n_tests++;
        if (hif.stall_cnt !== 32'd0 || hif.flush_cnt !== 32'd0) begin
            n_fail++; $display("FAIL rst_busy_cnt: got %0d/%0d expected 0/0", hif.stall_cnt, hif.flush_cnt);
        end
        @(negedge clk);
        idle_inputs();
        sb_push("rst_busy_late_done", ev(C_NORM, 1'b0, 1'b0, 2'b00, 2'b00));
        #1;
        e = sb_q.pop_front(); n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.v); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        exp_t e;
        idle_inputs();
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        n_tests++;
        if (hif.stall_cnt !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL wrap_preload: got %h expected ffffffff", hif.stall_cnt);
        end
        hif.mem_readE = 1'b1; hif.rdE = 5'd5; hif.rs1D = 5'd5; hif.rs1_useD = 1'b1;
        sb_push("wrap_stall", ev(C_LU, 1'b0, 1'b0, 2'b00, 2'b00));
        #1;
        e = sb_q.pop_front(); n_tests++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b expected %b", e.tag, obs, e.v); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++;
        if (hif.stall_cnt !== 32'h0000_0000) begin
            n_fail++; $display("FAIL wrap_cnt: got %h expected 00000000", hif.stall_cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_redirect();
        test_mdu();
        test_fwd();
        test_reset_busy();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard controller for the 5-stage RV32IZ pipeline. It drives the enable (`en`) and clear (`clc`) inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC enable. It also generates the EX-stage operand forwarding selects and sequences the multi-cycle multiply/divide unit (MDU) through a start/done handshake. Stall and flush event counters are exposed for debug.

## Interface
- No parameters; all widths fixed (RV32, 5-bit register indices).
- `clk` in 1: pipeline clock, all state updates on posedge.
- `rstn` in 1: synchronous, active-low reset.
- `rs1D`, `rs2D` in 5 each: source registers of the instruction in ID.
- `rs1_useD`, `rs2_useD` in 1 each: ID instruction actually reads rs1/rs2.
- `rs1E`, `rs2E` in 5 each: source registers of the instruction in EX.
- `rdE` in 5: destination register in EX.
- `mem_readE` in 1: EX instruction is a load.
- `mduE` in 1: EX instruction is a mul/div op.
- `redirectE` in 1: EX resolved a taken branch or jump (PC redirect).
- `rdM` in 5, `reg_writeM` in 1: MEM-stage destination and write enable.
- `rdW` in 5, `reg_writeW` in 1: WB-stage destination and write enable.
- `mdu_done` in 1: MDU result valid this cycle.
- `enF` out 1: PC register enable.
- `enD`, `clcD` out 1 each: IF/ID register controls.
- `enE`, `clcE` out 1 each: ID/EX register controls.
- `enM`, `clcM` out 1 each: EX/MEM register controls.
- `fwdAE`, `fwdBE` out 2 each: forwarding selects; 00 = register file, 01 = WB, 10 = MEM.
- `mdu_start` out 1: one-cycle start pulse to the MDU.
- `mdu_busy` out 1: state == BUSY.
- `stall_cnt` out 32: cycles with `enF`=0.
- `flush_cnt` out 32: cycles with a redirect accepted.

## Operation
- Pipeline-register semantics: a register loads only when its `en`=1. When `clc`=1 as well, it loads zero (a bubble). This block never asserts `clcX` with `enX`=0.
- MDU FSM, two states:
  - IDLE: if `mduE`, assert `mdu_start` and go to BUSY. `mdu_done` is ignored in IDLE.
  - BUSY: hold until `mdu_done`=1, then go to IDLE.
- `mdu_stall` = (IDLE & `mduE`) | (BUSY & ~`mdu_done`).
- `load_use` = `mem_readE` & `rdE`≠0 & ((`rs1_useD` & `rdE`==`rs1D`) | (`rs2_useD` & `rdE`==`rs2D`)).
- Priority, highest first:
  - `mdu_stall`: `enF`=`enD`=`enE`=0; `enM`=1, `clcM`=1 (bubble into MEM). Any `redirectE` or `load_use` is held off until EX is released.
  - `redirectE`: `enF`=1; `enD`=`clcD`=1; `enE`=`clcE`=1. This squashes the wrong-path instructions in IF and ID, and overrides a concurrent `load_use`. Increment `flush_cnt`.
  - `load_use`: `enF`=`enD`=0; `enE`=`clcE`=1.
  - Otherwise all `en`=1 and all `clc`=0.
- `stall_cnt` increments every non-reset cycle with `enF`=0. Both counters wrap modulo 2^32.
- Forwarding select for source A (B is identical, using `rs2E`):
  - 10 if `reg_writeM` & `rdM`≠0 & `rdM`==`rs1E`.
  - else 01 if `reg_writeW` & `rdW`≠0 & `rdW`==`rs1E`.
  - else 00.
  - MEM wins over WB. x0 is never forwarded.
- Reset (`rstn`=0 at a posedge):
  - FSM returns to IDLE and both counters clear to 0.
  - While `rstn`=0, combinationally `enF`=1, `enD`=`enE`=`enM`=1, `clcD`=`clcE`=`clcM`=1, `mdu_start`=0, `fwdAE`=`fwdBE`=00.
  - Reset during BUSY abandons the MDU op; the MDU is reset by the same `rstn`.

## Timing
- All `en`/`clc`/`fwd` outputs and `mdu_start` are combinational from the current inputs and FSM state, with zero-cycle latency. They must settle before the posedge.
- Outputs after the reset edge: FSM IDLE, counters 0, `mdu_busy`=0.
- MDU op of latency N:
  - `mdu_start` is high in EX cycle 0 only.
  - BUSY runs from cycle 1 until `mdu_done`.
  - The op leaves EX at the edge ending the `mdu_done` cycle.
  - Total EX occupancy is (cycles until `mdu_done`)+1. `mdu_done` earlier than cycle 1 is illegal.
- Back-to-back MDU ops: the second enters EX after the first's done edge and sees IDLE, so it receives its own `mdu_start`.
- Load-use costs exactly one bubble. Redirect costs two bubbles.

## Test plan
- Load-use: `mem_readE`=1, `rdE`=5, `rs1D`=5, `rs1_useD`=1 → `enF`=`enD`=0, `enE`=`clcE`=1 for exactly 1 cycle; `stall_cnt` goes 0→1. With `rdE`=0 → no stall.
- Redirect beats load-use: the load-use stimulus above plus `redirectE`=1 → `enF`=1, `clcD`=`clcE`=1; `flush_cnt`=1; `stall_cnt` unchanged.
- MDU, `mdu_done` returned 4 cycles after start → `mdu_start` pulses once; `mdu_busy` high for 4 cycles; `enE`=0 for 4 cycles; `clcM`=1 for 4 cycles; `stall_cnt`=4. A `redirectE` asserted mid-BUSY has no effect. Repeat back-to-back → two `mdu_start` pulses.
- Forwarding: `rs1E`=`rdM`=`rdW`=7, both write enables 1 → `fwdAE`=10. With `reg_writeM`=0 → 01. With all indices 0 → 00. Check `fwdBE` symmetrically.
- Reset mid-BUSY: `rstn`=0 for 1 cycle at BUSY cycle 2 → all `en`=`clc`=1 during reset; afterwards IDLE, `mdu_busy`=0, counters 0; a `mdu_done` arriving after reset is ignored.
- Counter wrap: preload `stall_cnt` to 0xFFFFFFFF via a forced stall sequence or backdoor, apply one stall → 0x00000000.
